// File: rtl/reg_byte_loader.sv
// rtl/reg_byte_loader.sv - byte-wise loader driving a 16-bit register through function selects
// Define LOADER_HIGH_FIRST_EN to take the high byte first in word mode (Mode 00).
module reg_byte_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Mode,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        RegE,
    output logic [2:0]  RegFunSel,
    output logic [15:0] RegI,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_ZX    = 2'b01;
    localparam logic [1:0] MODE_SX    = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam logic [2:0] FS_CLEAR = 3'b011;
    localparam logic [2:0] FS_LO_ZX = 3'b100;
    localparam logic [2:0] FS_LO    = 3'b101;
    localparam logic [2:0] FS_HI    = 3'b110;
    localparam logic [2:0] FS_LO_SX = 3'b111;

`ifdef LOADER_HIGH_FIRST_EN
    localparam bit HIGH_FIRST = 1'b1;
`else
    localparam bit HIGH_FIRST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LO,
        WAIT_HI,
        WRITE,
        CLEAR
    } state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             final_write;

    logic             in_wait;
    logic             xfer;
    logic             timeout_hit;
    logic [2:0]       word1_sel;
    logic [2:0]       word2_sel;
    logic [15:0]      word1_data;
    logic [15:0]      word2_data;

    assign in_wait   = (state == WAIT_LO) || (state == WAIT_HI);
    assign ByteReady = in_wait;
    assign Busy      = (state != IDLE);
    assign xfer      = in_wait && ByteValid;

    // A byte arriving on the limit cycle wins over the abort, so the abort is qualified by !ByteValid.
    assign timeout_hit = TIMEOUT_EN && in_wait && (wait_cnt == CNT_LIMIT) && !ByteValid;
    assign Timeout     = timeout_hit;

    always_comb begin
        word1_sel  = FS_LO;
        word1_data = {8'h00, ByteIn};
        word2_sel  = FS_HI;
        word2_data = {ByteIn, 8'h00};
        if (HIGH_FIRST) begin
            word1_sel  = FS_HI;
            word1_data = {ByteIn, 8'h00};
            word2_sel  = FS_LO;
            word2_data = {8'h00, ByteIn};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            mode_q      <= MODE_WORD;
            wait_cnt    <= '0;
            final_write <= 1'b0;
            RegE        <= 1'b0;
            RegFunSel   <= 3'b000;
            RegI        <= 16'h0000;
            Done        <= 1'b0;
        end else begin
            RegE <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mode_q <= Mode;
                        if (Mode == MODE_CLEAR) begin
                            state     <= CLEAR;
                            RegE      <= 1'b1;
                            RegFunSel <= FS_CLEAR;
                            Done      <= 1'b1;
                        end else begin
                            state    <= WAIT_LO;
                            wait_cnt <= '0;
                        end
                    end
                end

                WAIT_LO: begin
                    if (xfer) begin
                        state <= WRITE;
                        RegE  <= 1'b1;
                        case (mode_q)
                            MODE_ZX: begin
                                RegFunSel   <= FS_LO_ZX;
                                RegI        <= {8'h00, ByteIn};
                                Done        <= 1'b1;
                                final_write <= 1'b1;
                            end
                            MODE_SX: begin
                                RegFunSel   <= FS_LO_SX;
                                RegI        <= {8'h00, ByteIn};
                                Done        <= 1'b1;
                                final_write <= 1'b1;
                            end
                            default: begin
                                RegFunSel   <= word1_sel;
                                RegI        <= word1_data;
                                final_write <= 1'b0;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                WAIT_HI: begin
                    if (xfer) begin
                        state       <= WRITE;
                        RegE        <= 1'b1;
                        RegFunSel   <= word2_sel;
                        RegI        <= word2_data;
                        Done        <= 1'b1;
                        final_write <= 1'b1;
                    end else if (timeout_hit) begin
                        // The first byte stays in the downstream register; there is no rollback.
                        state <= IDLE;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                WRITE: begin
                    if (final_write) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT_HI;
                        wait_cnt <= '0;
                    end
                end

                CLEAR: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_byte_loader.sv
// tb/tb_reg_byte_loader.sv - directed self-checking bench for reg_byte_loader
module tb_reg_byte_loader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Mode;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        RegE;
    logic [2:0]  RegFunSel;
    logic [15:0] RegI;
    logic        Busy;
    logic        Done;
    logic        Timeout;

    always #5 Clock = ~Clock;

    reg_byte_loader #(.TIMEOUT_CYCLES(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .RegE      (RegE),
        .RegFunSel (RegFunSel),
        .RegI      (RegI),
        .Busy      (Busy),
        .Done      (Done),
        .Timeout   (Timeout)
    );

`ifdef LOADER_HIGH_FIRST_EN
    localparam logic [7:0]  W_B1 = 8'h12;
    localparam logic [7:0]  W_B2 = 8'h34;
    localparam logic [2:0]  W1_SEL = 3'b110;
    localparam logic [15:0] W1_DATA = 16'h1200;
    localparam logic [2:0]  W2_SEL = 3'b101;
    localparam logic [15:0] W2_DATA = 16'h0034;
    localparam logic [15:0] T1_DATA = 16'h5600;
`else
    localparam logic [7:0]  W_B1 = 8'h34;
    localparam logic [7:0]  W_B2 = 8'h12;
    localparam logic [2:0]  W1_SEL = 3'b101;
    localparam logic [15:0] W1_DATA = 16'h0034;
    localparam logic [2:0]  W2_SEL = 3'b110;
    localparam logic [15:0] W2_DATA = 16'h1200;
    localparam logic [15:0] T1_DATA = 16'h0056;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int rege_cnt = 0;
    int overlap_cnt = 0;
    int d0;
    int r0;
    logic [15:0] dreg;

    // Downstream 16-bit register as the function selects define it.
    always @(posedge Clock) begin
        if (Reset) dreg <= 16'h0000;
        else if (RegE) begin
            case (RegFunSel)
                3'b011: dreg <= 16'h0000;
                3'b100: dreg <= {8'h00, RegI[7:0]};
                3'b101: dreg <= {dreg[15:8], RegI[7:0]};
                3'b110: dreg <= {RegI[15:8], dreg[7:0]};
                3'b111: dreg <= {{8{RegI[7]}}, RegI[7:0]};
                default: dreg <= dreg;
            endcase
        end
    end

    always @(negedge Clock) begin
        if (Done) done_cnt++;
        if (RegE) rege_cnt++;
        if (Done && Timeout) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] m, input logic v, input logic [7:0] b);
        Start     = s;
        Mode      = m;
        ByteValid = v;
        ByteIn    = b;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        drive(1'b1, 2'b11, 1'b1, 8'hFF);
        cyc(); cyc();
        drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("rst_outputs", {ByteReady, RegE, Busy, Done, Timeout, RegFunSel, RegI}, 32'h0);
        Reset = 1'b0;

        // Word load
        d0 = done_cnt;
        cyc(); drive(1'b1, 2'b00, 1'b0, 8'h00);
        check("w_idle_busy", Busy, 0);
        cyc(); drive(1'b0, 2'b00, 1'b1, W_B1);
        check("w_lo_flags", {Busy, ByteReady, RegE}, 3'b110);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("w_wr1_sel", RegFunSel, W1_SEL);
        check("w_wr1_data", RegI, W1_DATA);
        check("w_wr1_flags", {RegE, Done, ByteReady}, 3'b100);
        cyc(); drive(1'b0, 2'b00, 1'b1, W_B2);
        check("w_hi_hold", {ByteReady, RegE, RegI}, {1'b1, 1'b0, W1_DATA});
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("w_wr2_sel", RegFunSel, W2_SEL);
        check("w_wr2_data", RegI, W2_DATA);
        check("w_wr2_flags", {RegE, Done, Timeout}, 3'b110);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("w_end_flags", {Busy, RegE, Done}, 3'b000);
        check("w_dreg", dreg, 16'h1234);
        check("w_done_cnt", done_cnt - d0, 1);

        // Sign-extended byte
        cyc(); drive(1'b1, 2'b10, 1'b0, 8'h00);
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'h80);
        check("sx_ready", ByteReady, 1);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("sx_sel", RegFunSel, 3'b111);
        check("sx_data", RegI, 16'h0080);
        check("sx_flags", {RegE, Done}, 2'b11);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("sx_idle", {Busy, RegE, Done}, 3'b000);
        check("sx_dreg", dreg, 16'hFF80);

        // Zero-extended byte with Start pulsed while busy
        d0 = done_cnt;
        cyc(); drive(1'b1, 2'b01, 1'b0, 8'h00);
        cyc(); drive(1'b1, 2'b11, 1'b0, 8'h00);
        cyc(); drive(1'b1, 2'b11, 1'b0, 8'h00);
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'hA5);
        check("zx_wait_flags", {Busy, ByteReady, Timeout}, 3'b110);
        cyc(); drive(1'b1, 2'b11, 1'b0, 8'h00);
        check("zx_sel", RegFunSel, 3'b100);
        check("zx_data", RegI, 16'h00A5);
        check("zx_flags", {RegE, Done}, 2'b11);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("zx_idle", Busy, 0);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("zx_no_queue", {Busy, RegE, Done}, 3'b000);
        check("zx_dreg", dreg, 16'h00A5);
        check("zx_done_cnt", done_cnt - d0, 1);

        // Clear, with ByteValid held high throughout
        cyc(); drive(1'b1, 2'b11, 1'b1, 8'hEE);
        check("clr_idle_ready", ByteReady, 0);
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'hEE);
        check("clr_flags", {RegE, Done, ByteReady, Busy}, 4'b1101);
        check("clr_sel", RegFunSel, 3'b011);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("clr_after", {ByteReady, Busy, RegE, Done}, 4'b0000);
        check("clr_dreg", dreg, 16'h0000);

        // Timeout in WAIT_HI after the first byte
        r0 = rege_cnt;
        cyc(); drive(1'b1, 2'b00, 1'b0, 8'h00);
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'h56);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("to_enter", {ByteReady, Timeout}, 2'b10);
        repeat (2) begin
            cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        end
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("to_early", Timeout, 0);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("to_pulse", {Timeout, Busy, RegE, Done}, 4'b1100);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("to_after", {Timeout, Busy, RegE, ByteReady}, 4'b0000);
        check("to_rege_cnt", rege_cnt - r0, 1);
        check("to_dreg", dreg, T1_DATA);
        check("to_regi_hold", RegI, T1_DATA);

        // Byte on the limit cycle wins over the timeout
        cyc(); drive(1'b1, 2'b01, 1'b0, 8'h00);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        repeat (3) begin
            cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        end
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'h7F);
        check("pri_no_to", {ByteReady, Timeout}, 2'b10);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("pri_flags", {RegE, Done, Timeout}, 3'b110);
        check("pri_sel", RegFunSel, 3'b100);
        check("pri_data", RegI, 16'h007F);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("pri_idle", Busy, 0);

        // Reset during WAIT_HI
        cyc(); drive(1'b1, 2'b00, 1'b0, 8'h00);
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'h11);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        cyc(); Reset = 1'b1; drive(1'b1, 2'b00, 1'b1, 8'h22);
        check("rh_before", ByteReady, 1);
        cyc(); Reset = 1'b0; drive(1'b0, 2'b00, 1'b1, 8'h22);
        check("rh_outputs", {ByteReady, RegE, Busy, Done, Timeout, RegFunSel, RegI}, 32'h0);
        cyc(); drive(1'b0, 2'b00, 1'b1, 8'h33);
        check("rh_no_accept", {ByteReady, RegE, Busy, Done, Timeout}, 5'b00000);
        cyc(); drive(1'b0, 2'b00, 1'b0, 8'h00);
        check("rh_regi", {RegE, RegI}, 17'h0);

        check("done_timeout_overlap", overlap_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_byte_loader.md
REG_BYTE_LOADER -- requirements
Module: reg_byte_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max idle cycles in a wait state before abort; 0 disables the timeout.
REQ-002 Port: Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Start  input  1  begin a load operation; sampled only in IDLE.
REQ-005 Port: Mode  input  2  operation select, sampled with Start: 00 word (two bytes), 01 byte zero-extend, 10 byte sign-extend, 11 clear.
REQ-006 Port: ByteIn  input  8  byte data from the memory side.
REQ-007 Port: ByteValid  input  1  ByteIn holds a valid byte.
REQ-008 Port: ByteReady  output  1  loader accepts a byte this cycle.
REQ-009 Port: RegE  output  1  enable for the downstream 16-bit register.
REQ-010 Port: RegFunSel  output  3  function select for the downstream register.
REQ-011 Port: RegI  output  16  data for the downstream register.
REQ-012 Port: Busy  output  1  high in every state except IDLE.
REQ-013 Port: Done  output  1  one-cycle pulse on completion.
REQ-014 Port: Timeout  output  1  one-cycle pulse on abort.

Function
REQ-015 States SHALL be IDLE, WAIT_LO, WAIT_HI, WRITE, CLEAR.
REQ-016 A byte transfer SHALL occur on a cycle with ByteValid=1 and ByteReady=1; ByteReady SHALL be 1 only in WAIT_LO and WAIT_HI.
REQ-017 In IDLE, Start=1 SHALL latch Mode; Mode 11 SHALL go to CLEAR, and all other modes SHALL go to WAIT_LO.
REQ-018 CLEAR SHALL drive RegE=1, RegFunSel=011, and Done=1 for one cycle, then return to IDLE.
REQ-019 A transfer in WAIT_LO SHALL, in the next cycle (WRITE), drive RegE=1 and RegI={8'h00,byte}, with RegFunSel=101 for Mode 00, 100 for Mode 01, and 111 for Mode 10.
REQ-020 After this WRITE: Mode 00 SHALL go to WAIT_HI; Modes 01 and 10 SHALL assert Done in the same WRITE cycle and go to IDLE.
REQ-021 A transfer in WAIT_HI SHALL, in the next cycle (WRITE), drive RegE=1, RegFunSel=110, RegI={byte,8'h00}, and Done=1, then go to IDLE.
REQ-022 Outside CLEAR and WRITE, RegE SHALL be 0; RegFunSel and RegI SHALL hold their last values.
REQ-023 Start asserted while Busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-024 A wait counter SHALL clear on entry to each wait state and increment each wait cycle without a transfer.
REQ-025 When the counter reaches TIMEOUT_CYCLES (nonzero), the block SHALL go to IDLE, pulse Timeout for one cycle, and issue no further RegE.
REQ-026 On a Mode 00 timeout in WAIT_HI, the low byte already written SHALL remain in place; the block SHALL NOT roll it back.
REQ-027 A transfer on the same cycle the counter reaches the limit SHALL take priority over the timeout.
REQ-028 Done and Timeout SHALL never be asserted together.

Reset
REQ-029 Reset=1 at a rising edge SHALL force IDLE and clear the counter, with all outputs 0: ByteReady, RegE, Busy, Done, Timeout, RegFunSel=000, RegI=16'h0000.
REQ-030 Reset SHALL override Start and any in-flight transfer; a reset in WAIT_HI SHALL produce no RegE, Done, or Timeout.

Configuration
REQ-031 The macro LOADER_HIGH_FIRST_EN SHALL control byte order in Mode 00.
REQ-032 With LOADER_HIGH_FIRST_EN defined, Mode 00 SHALL accept the high byte first; the first WRITE SHALL be RegFunSel=110, RegI={byte,8'h00}, and the second WRITE SHALL be RegFunSel=101, RegI={8'h00,byte}, with Done on the second.
REQ-033 Without LOADER_HIGH_FIRST_EN, byte order SHALL be as in REQ-019 to REQ-021.
REQ-034 Modes 01, 10, and 11 SHALL be unaffected by the macro.

Verification
REQ-035 Mode 00, bytes 0x34 then 0x12 -> WRITE FunSel=101, RegI=0x0034; then WRITE FunSel=110, RegI=0x1200 with Done=1; downstream register reads 0x1234.
REQ-036 Mode 10, byte 0x80 -> single WRITE, FunSel=111, RegI=0x0080, Done=1; downstream register reads 0xFF80.
REQ-037 Mode 11 -> one cycle of RegE=1, FunSel=011, Done=1; ByteReady stays 0 throughout.
REQ-038 TIMEOUT_CYCLES=4, Mode 00, low byte sent, no high byte -> Timeout=1 four cycles after entering WAIT_HI, no second RegE, Busy=0 next cycle.
REQ-039 Reset=1 during WAIT_HI -> next cycle all outputs 0; a subsequent ByteValid=1 is not accepted.
REQ-040 Start pulsed while Busy=1 -> ignored; exactly one Done per accepted Start.
